// File: rtl/avalon_anemo_cpu_debug_pkg.sv
// Shared types and JTAG data-out field positions for the debug memory sequencer.
package avalon_anemo_cpu_debug_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BE_W      = 4;
  localparam int unsigned JDO_W     = 38;
  localparam int unsigned WDATA_LSB = 3;
  localparam int unsigned ADDR_LSB  = 17;
  localparam int unsigned RD_FLAG   = 35;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_DATA
  } state_e;

  typedef enum logic {
    JTAG,
    AVALON
  } grant_e;

endpackage

// File: rtl/avalon_anemo_cpu_debug_rr_arb.sv
// Two-way round-robin arbiter between the JTAG queue and the Avalon slave.
module avalon_anemo_cpu_debug_rr_arb
  import avalon_anemo_cpu_debug_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   i_en,
  input  logic   i_req_jtag,
  input  logic   i_req_av,
  output logic   o_gnt_valid_c,
  output grant_e o_gnt_c
);

  grant_e r_last_grant;

  // On contention, favour whichever side was not granted last.
  always_comb begin
    o_gnt_valid_c = i_req_jtag | i_req_av;
    o_gnt_c       = AVALON;
    if (i_req_jtag && i_req_av) begin
      o_gnt_c = (r_last_grant == AVALON) ? JTAG : AVALON;
    end else if (i_req_jtag) begin
      o_gnt_c = JTAG;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= AVALON;
    end else if (i_en && o_gnt_valid_c) begin
      r_last_grant <= o_gnt_c;
    end
  end

endmodule

// File: rtl/avalon_anemo_cpu_debug_mem_sequencer.sv
// Sequences JTAG debug strobes and Avalon debug_mem accesses onto the single-port debug RAM.
module avalon_anemo_cpu_debug_mem_sequencer
  import avalon_anemo_cpu_debug_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [JDO_W-1:0]  jdo,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [DATA_W-1:0] av_writedata,
  input  logic [BE_W-1:0]   av_byteenable,
  output logic [DATA_W-1:0] av_readdata,
  output logic              av_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [BE_W-1:0]   ram_be,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  state_e              r_state;
  logic [ADDR_W-1:0]   r_mon_a;
  logic                r_jtag_pend;
  logic                r_jtag_is_wr;
  logic [DATA_W-1:0]   r_jtag_wdata;
  logic                r_op_jtag;

  logic                w_strobe;
  logic                w_busy;
  logic                w_av_req;
  logic                w_gnt_valid;
  grant_e              w_gnt;
  logic                w_jdo_unused;

  assign w_strobe     = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign w_busy       = r_jtag_pend | ((r_state != IDLE) & r_op_jtag);
  // An Avalon request already acknowledged this cycle must not be granted again.
  assign w_av_req     = (av_read | av_write) & av_waitrequest;
  assign w_jdo_unused = ^{jdo[JDO_W-1:RD_FLAG+1], jdo[WDATA_LSB-1:0]};

  avalon_anemo_cpu_debug_rr_arb u_arb (
    .clk           (clk),
    .reset         (reset),
    .i_en          (r_state == IDLE),
    .i_req_jtag    (r_jtag_pend),
    .i_req_av      (w_av_req),
    .o_gnt_valid_c (w_gnt_valid),
    .o_gnt_c       (w_gnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_mon_a        <= '0;
      r_jtag_pend    <= 1'b0;
      r_jtag_is_wr   <= 1'b0;
      r_jtag_wdata   <= '0;
      r_op_jtag      <= 1'b0;
      MonDReg        <= '0;
      monitor_ready  <= 1'b1;
      monitor_error  <= 1'b0;
      ram_we         <= 1'b0;
      ram_addr       <= '0;
      ram_wdata      <= '0;
      ram_be         <= '0;
      av_readdata    <= '0;
      av_waitrequest <= 1'b1;
    end else begin
      // JTAG strobe intake: b > a > no_action, overrun drops the strobe and flags it.
      if (w_strobe) begin
        if (w_busy) begin
          monitor_error <= 1'b1;
        end else if (take_action_ocimem_b) begin
          r_jtag_pend   <= 1'b1;
          r_jtag_is_wr  <= 1'b1;
          r_jtag_wdata  <= jdo[WDATA_LSB +: DATA_W];
          monitor_ready <= 1'b0;
        end else if (take_action_ocimem_a) begin
          r_mon_a       <= jdo[ADDR_LSB +: ADDR_W];
          monitor_error <= 1'b0;
          if (jdo[RD_FLAG]) begin
            r_jtag_pend   <= 1'b1;
            r_jtag_is_wr  <= 1'b0;
            monitor_ready <= 1'b0;
          end
        end else begin
          r_jtag_pend   <= 1'b1;
          r_jtag_is_wr  <= 1'b0;
          monitor_ready <= 1'b0;
        end
      end

      case (r_state)
        IDLE: begin
          av_waitrequest <= 1'b1;
          if (w_gnt_valid) begin
            r_op_jtag <= (w_gnt == JTAG);
            if (w_gnt == JTAG) begin
              ram_addr  <= r_mon_a;
              ram_wdata <= r_jtag_wdata;
              ram_be    <= {BE_W{1'b1}};
              ram_we    <= r_jtag_is_wr;
              r_state   <= r_jtag_is_wr ? WR : RD_ISSUE;
            end else begin
              ram_addr       <= av_address;
              ram_wdata      <= av_writedata;
              ram_be         <= av_byteenable;
              ram_we         <= av_write;
              av_waitrequest <= ~av_write;
              r_state        <= av_write ? WR : RD_ISSUE;
            end
          end
        end
        WR: begin
          ram_we         <= 1'b0;
          av_waitrequest <= 1'b1;
          r_state        <= IDLE;
          if (r_op_jtag) begin
            r_mon_a       <= r_mon_a + ADDR_W'(1);
            r_jtag_pend   <= 1'b0;
            monitor_ready <= 1'b1;
          end
        end
        RD_ISSUE: begin
          r_state <= RD_DATA;
        end
        RD_DATA: begin
          r_state <= IDLE;
          // Read data lands here; Avalon sees it together with waitrequest low next cycle.
          if (r_op_jtag) begin
            MonDReg       <= ram_rdata;
            r_mon_a       <= r_mon_a + ADDR_W'(1);
            r_jtag_pend   <= 1'b0;
            monitor_ready <= 1'b1;
          end else begin
            av_readdata    <= ram_rdata;
            av_waitrequest <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_anemo_cpu_debug_mem_sequencer.sv
// Randomized self-checking bench: debug RAM model plus a word-level reference of memory and JTAG address.
`timescale 1ns/1ps
module tb_avalon_anemo_cpu_debug_mem_sequencer;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [37:0]   jdo;
  logic [AW-1:0] av_address;
  logic          av_read, av_write;
  logic [31:0]   av_writedata;
  logic [3:0]    av_byteenable;
  logic [31:0]   av_readdata;
  logic          av_waitrequest;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [3:0]    ram_be;
  logic          ram_we;
  logic [31:0]   ram_rdata;
  logic [31:0]   MonDReg;
  logic          monitor_ready, monitor_error;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0]   mem     [256];
  logic [31:0]   ref_mem [256];
  logic [AW-1:0] ref_a;

  always #5 clk = ~clk;

  avalon_anemo_cpu_debug_mem_sequencer #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .jdo(jdo),
    .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_byteenable(av_byteenable),
    .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_we(ram_we),
    .ram_rdata(ram_rdata),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  // Single-port RAM, one-cycle registered read, byte-enabled write.
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [37:0] jdo_rand();
    return {6'($urandom), 32'($urandom)};
  endfunction

  function automatic logic [37:0] jdo_a(input logic [AW-1:0] a, input logic rd);
    logic [37:0] j;
    j = jdo_rand();
    j[24:17] = a;
    j[35] = rd;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] j;
    j = jdo_rand();
    j[34:3] = d;
    return j;
  endfunction

  // kind: 0 = a, 1 = no_action_a, 2 = b, 3 = a and b together
  task automatic strobe(input int kind, input logic [37:0] j);
    jdo = j;
    take_action_ocimem_a    = (kind == 0 || kind == 3);
    take_no_action_ocimem_a = (kind == 1);
    take_action_ocimem_b    = (kind == 2 || kind == 3);
    tick();
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
  endtask

  task automatic wait_ready(input string tag, output int n);
    n = 0;
    while (!monitor_ready && n < 50) begin
      tick();
      n++;
    end
    if (!monitor_ready) chk({tag, "_ready_timeout"}, 32'(monitor_ready), 32'd1);
  endtask

  task automatic jtag_wr(input logic [31:0] d);
    int n;
    strobe(2, jdo_b(d));
    wait_ready("jwr", n);
    ref_mem[ref_a] = d;
    ref_a++;
  endtask

  task automatic jtag_rd(input string tag);
    int n;
    strobe(1, jdo_rand());
    wait_ready(tag, n);
    chk(tag, MonDReg, ref_mem[ref_a]);
    ref_a++;
  endtask

  task automatic jtag_load(input logic [AW-1:0] a, input logic rd);
    int n;
    strobe(0, jdo_a(a, rd));
    ref_a = a;
    if (rd) begin
      wait_ready("jld", n);
      chk("jld_rd", MonDReg, ref_mem[ref_a]);
      ref_a++;
    end else begin
      chk("jld_noread_ready", 32'(monitor_ready), 32'd1);
    end
  endtask

  task automatic av_wait(input string tag);
    int n;
    n = 0;
    tick();
    while (av_waitrequest && n < 50) begin
      tick();
      n++;
    end
    if (av_waitrequest) chk({tag, "_wait_timeout"}, 32'(av_waitrequest), 32'd0);
  endtask

  task automatic av_rd(input logic [AW-1:0] a, output logic [31:0] d);
    av_address = a;
    av_read    = 1'b1;
    av_wait("avrd");
    d = av_readdata;
    tick();
    av_read = 1'b0;
  endtask

  task automatic av_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    av_address    = a;
    av_writedata  = d;
    av_byteenable = be;
    av_write      = 1'b1;
    av_wait("avwr");
    chk("avwr_we", 32'(ram_we), 32'd1);
    chk("avwr_be", 32'(ram_be), 32'(be));
    chk("avwr_addr", 32'(ram_addr), 32'(a));
    chk("avwr_data", ram_wdata, d);
    tick();
    av_write = 1'b0;
    chk("avwr_we_one_cycle", 32'(ram_we), 32'd0);
    ref_mem[a] = merge(ref_mem[a], d, be);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(monitor_ready), 32'd1);
    chk({tag, "_error"}, 32'(monitor_error), 32'd0);
    chk({tag, "_mond"}, MonDReg, 32'd0);
    chk({tag, "_we"}, 32'(ram_we), 32'd0);
    chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_wdata"}, ram_wdata, 32'd0);
    chk({tag, "_be"}, 32'(ram_be), 32'd0);
    chk({tag, "_avrd"}, av_readdata, 32'd0);
    chk({tag, "_avwait"}, 32'(av_waitrequest), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [AW-1:0] a;
    int n, diffs;

    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    ref_a = '0;
    reset = 1'b1;
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    jdo = '0; av_address = '0; av_read = 1'b0; av_write = 1'b0;
    av_writedata = '0; av_byteenable = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_reset_outputs("rst");

    // Address load with read, then auto-incremented read.
    av_wr(8'h10, 32'hDEADBEEF, 4'hF);
    av_wr(8'h11, 32'h12345678, 4'hF);
    strobe(0, jdo_a(8'h10, 1'b1));
    chk("t1_ready_low", 32'(monitor_ready), 32'd0);
    wait_ready("t1", n);
    chk("t1_latency", 32'(n), 32'd3);
    chk("t1_mond", MonDReg, 32'hDEADBEEF);
    ref_a = 8'h11;
    jtag_rd("t1_next_addr");

    // Writes wrapping the top of the address space.
    jtag_load(8'hFE, 1'b0);
    jtag_wr(32'd1);
    jtag_wr(32'd2);
    jtag_wr(32'd3);
    chk("t2_mem_fe", mem[8'hFE], 32'd1);
    chk("t2_mem_ff", mem[8'hFF], 32'd2);
    chk("t2_mem_00", mem[8'h00], 32'd3);
    chk("t2_error", 32'(monitor_error), 32'd0);
    jtag_rd("t2_after_wrap");

    // Back-to-back strobes: second is an overrun.
    d = $urandom;
    a = ref_a;
    strobe(2, jdo_b(d));
    strobe(2, jdo_b(~d));
    wait_ready("t4", n);
    ref_mem[ref_a] = d;
    ref_a++;
    chk("t4_error_set", 32'(monitor_error), 32'd1);
    chk("t4_first_written", mem[a], d);
    chk("t4_second_dropped", mem[a + AW'(1)], ref_mem[a + AW'(1)]);
    jtag_load(8'h40, 1'b0);
    chk("t4_error_cleared", 32'(monitor_error), 32'd0);

    // Simultaneous a and b strobes: b wins, address unchanged, no error.
    d = $urandom;
    a = ref_a;
    strobe(3, jdo_b(d));
    wait_ready("prio", n);
    ref_mem[ref_a] = d;
    ref_a++;
    chk("prio_mem", mem[a], d);
    chk("prio_error", 32'(monitor_error), 32'd0);

    // Partial-byte Avalon write.
    av_wr(8'h33, 32'hAABBCCDD, 4'b0011);
    chk("t5_mem", mem[8'h33], ref_mem[8'h33]);

    // Contention after an Avalon grant: JTAG first.
    a = 8'h77;
    strobe(1, jdo_rand());
    av_address = a;
    av_read = 1'b1;
    av_wait("t3");
    chk("t3_jtag_done_first", 32'(monitor_ready), 32'd1);
    chk("t3_mond", MonDReg, ref_mem[ref_a]);
    chk("t3_avdata", av_readdata, ref_mem[a]);
    tick();
    av_read = 1'b0;
    ref_a++;

    // Contention after a JTAG grant: Avalon first.
    jtag_wr($urandom);
    a = 8'h78;
    strobe(1, jdo_rand());
    av_address = a;
    av_read = 1'b1;
    av_wait("t3b");
    chk("t3b_jtag_still_pending", 32'(monitor_ready), 32'd0);
    chk("t3b_avdata", av_readdata, ref_mem[a]);
    tick();
    av_read = 1'b0;
    wait_ready("t3b", n);
    chk("t3b_mond", MonDReg, ref_mem[ref_a]);
    ref_a++;

    // Reset in the middle of a JTAG read.
    strobe(1, jdo_rand());
    tick();
    chk("t6_issue_addr", 32'(ram_addr), 32'(ref_a));
    reset = 1'b1;
    #2;
    check_reset_outputs("t6_async");
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("t6_mond_no_update", MonDReg, 32'd0);
    chk("t6_ready", 32'(monitor_ready), 32'd1);
    ref_a = '0;
    jtag_rd("t6_addr_reset");

    // Randomized sequential traffic.
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 5))
        0: jtag_wr($urandom);
        1: jtag_rd("rnd_jrd");
        2: jtag_load(AW'($urandom), 1'($urandom));
        3: begin
          a = AW'($urandom);
          av_rd(a, d);
          chk("rnd_avrd", d, ref_mem[a]);
        end
        4: av_wr(AW'($urandom), $urandom, 4'($urandom));
        default: jtag_load(AW'($urandom), 1'b1);
      endcase
    end
    chk("rnd_error", 32'(monitor_error), 32'd0);

    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("final_mem_diffs", 32'(diffs), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
